// File: rtl/instr_encoder_if.sv
// Bundle handshake and instruction-memory write bus for instr_encoder.
// slave is the encoder's view; master is the producer/memory side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ins_type;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        imm_flag;
    logic        set_flags;
    logic [4:0]  ldst_signals;
    logic [23:0] immediate;
    logic        last_instr;
    logic        mem_write_en;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_ready;

    modport slave (
        input  in_valid, ins_type, cond, opcode, rn, rd, rm, imm_flag, set_flags,
               ldst_signals, immediate, last_instr, mem_ready,
        output in_ready, mem_write_en, mem_address, mem_data
    );

    modport master (
        output in_valid, ins_type, cond, opcode, rn, rd, rm, imm_flag, set_flags,
               ldst_signals, immediate, last_instr, mem_ready,
        input  in_ready, mem_write_en, mem_address, mem_data
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 32-bit words and writes them to instruction memory.
// Optional bundle legality checking is enabled with the ENCODER_CHECK_EN macro.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ACCEPT | in_ready high, waiting for a field bundle
// WRITE  | holding the encoded word on the memory bus until mem_ready
// DONE   | session finished, waiting for a new start
module instr_encoder (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic [15:0]     word_count,
    output logic            done,
    output logic            error
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_q;
    logic        last_q;
    logic [11:0] operand12;
    logic [31:0] enc_word;
    logic        bundle_bad;

    always_comb begin
        operand12 = {8'b0, bus.rm};
        enc_word  = '0;
        case (bus.ins_type)
            2'b00: begin
                if (bus.imm_flag) operand12 = {4'b0, bus.immediate[7:0]};
                enc_word = {bus.cond, 2'b00, bus.imm_flag, bus.opcode, bus.set_flags,
                            bus.rn, bus.rd, operand12};
            end
            2'b01: begin
                if (bus.imm_flag) operand12 = bus.immediate[11:0];
                enc_word = {bus.cond, 2'b01, bus.imm_flag, bus.ldst_signals,
                            bus.rn, bus.rd, operand12};
            end
            2'b10:   enc_word = {bus.cond, 2'b10, 2'b00, bus.immediate};
            default: enc_word = {bus.cond, 2'b11, 26'b0};
        endcase
    end

`ifdef ENCODER_CHECK_EN
    logic error_q;

    // Immediates that would lose bits when packed, and the undefined type, are rejected.
    assign bundle_bad = (bus.ins_type == 2'b11)
                     || (bus.imm_flag && (bus.ins_type == 2'b00) && (|bus.immediate[23:8]))
                     || (bus.imm_flag && (bus.ins_type == 2'b01) && (|bus.immediate[23:12]));
    assign error = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            error_q <= 1'b0;
        end else if (state == ACCEPT && bus.in_valid && bundle_bad) begin
            error_q <= 1'b1;
        end
    end
`else
    assign bundle_bad = 1'b0;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = ACCEPT;
            ACCEPT: begin
                if (bus.in_valid) begin
                    if (bundle_bad) state_next = bus.last_instr ? DONE : ACCEPT;
                    else            state_next = WRITE;
                end
            end
            WRITE:  if (bus.mem_ready) state_next = last_q ? DONE : ACCEPT;
            DONE:   if (start) state_next = ACCEPT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_q <= '0;
            mem_data_q    <= '0;
            word_count    <= '0;
            last_q        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mem_address_q <= '0;
                        word_count    <= '0;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid && !bundle_bad) begin
                        mem_data_q <= enc_word;
                        last_q     <= bus.last_instr;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        // Address wraps naturally at 32 bits; the count saturates.
                        mem_address_q <= mem_address_q + 32'd4;
                        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state == ACCEPT);
    assign bus.mem_write_en = (state == WRITE);
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_data     = mem_data_q;
    assign done             = (state == DONE);
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the ports below; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins a program-load session at address 0.
REQ-005 inValid / inReady  in / out  1 / 1  field-bundle handshake; transfer when both are high on a clock edge.
REQ-006 insType  in  2  00 data-processing, 01 load/store, 10 branch, 11 undefined.
REQ-007 cond, opcode, rn, rd, rm  in  4 each  condition, ALU opcode, source, destination and offset registers.
REQ-008 immFlag, setFlags  in  1 each  I bit and S bit.
REQ-009 ldstSignals  in  5  P-U-B-W-L bits.
REQ-010 immediate  in  24  immediate, right-aligned.
REQ-011 lastInstr  in  1  marks the final bundle of the session.
REQ-012 memWriteEn  out  1  instruction-memory write request, held until memReady.
REQ-013 memAddress, memData  out  32 each  byte address and encoded word.
REQ-014 memReady  in  1  memory accepts the write this cycle.
REQ-015 wordCount  out  16  words written this session.
REQ-016 done  out  1  session complete.
REQ-017 error  out  1  sticky illegal-bundle flag; constant 0 when checking is compiled out.

Function
REQ-018 Encoding SHALL be {cond, insType, immFlag, opcode, setFlags, rn, rd, operand12} for type 00 and {cond, 01, immFlag, ldstSignals, rn, rd, operand12} for type 01, with operand12 = {4'b0, immediate[7:0]} (type 00) or immediate[11:0] (type 01) when immFlag=1, else {8'b0, rm}.
REQ-019 Type 10 SHALL encode as {cond, 10, 2'b00, immediate[23:0]}.
REQ-020 FSM states: IDLE, ACCEPT, WRITE, DONE.
REQ-021 IDLE: inReady=0; start -> ACCEPT, memAddress=0, wordCount=0, error=0.
REQ-022 ACCEPT: inReady=1; transfer -> WRITE with memData registered, so memWriteEn rises the cycle after the transfer.
REQ-023 WRITE: inReady=0; memWriteEn, memAddress and memData stable until memReady; on memReady memAddress+=4 (wraps 0xFFFFFFFC->0) and wordCount+=1 (saturates at 0xFFFF); then DONE if the captured lastInstr=1, else ACCEPT.
REQ-024 DONE: done=1, inReady=0; start -> ACCEPT with the same clears as from IDLE; start is ignored in ACCEPT and WRITE.
REQ-025 Maximum throughput SHALL be one word per 2 cycles.

Reset
REQ-026 While rst=0, all outputs SHALL be 0 and the state IDLE, independent of clk, including mid-write (memWriteEn drops immediately, the pending word is discarded).
REQ-027 After release the block SHALL wait in IDLE for start.

Configuration
REQ-028 Macro ENCODER_CHECK_EN: when defined, a bundle with insType=11, or immFlag=1 with immediate[23:8]!=0 (type 00) or immediate[23:12]!=0 (type 01), SHALL set error, be dropped without a write or count change, and go to DONE if lastInstr=1, else stay in ACCEPT.
REQ-029 When the macro is undefined, immediates SHALL be truncated per REQ-018, type 11 SHALL be written as {cond, 11, 26'b0}, and error SHALL be tied to 0.

Verification
REQ-030 start; ADD reg (cond 0, type 00, I 0, op 0000, S 0, rn A, rd B, rm D) -> write 0x000AB00D at address 0, wordCount 1.
REQ-031 Next bundle SUB imm (I 1, op 0001, S 1, rn A, rd B, imm 0xFF) -> 0x023AB0FF at address 4.
REQ-032 Load imm (type 01, I 1, ldst 00001, rn A, rd B, imm 0xF8F) -> 0x061ABF8F; branch with imm 0x99FBB8 and lastInstr=1 -> 0x0899FBB8, then done=1.
REQ-033 Hold memReady=0 for 3 cycles during WRITE -> memWriteEn, memAddress and memData stable, inReady=0, one write only; assert rst mid-WRITE -> all outputs 0 at once.
REQ-034 DP imm with immediate 0x100: with ENCODER_CHECK_EN, error=1, no write, wordCount unchanged; without it, 0x02...000 (low byte 0x00) is written.
